// File: rtl/matrix_digit_ctrl_pkg.sv
// Shared types and constants for the matrix digit controller.
package matrix_digit_ctrl_pkg;

  typedef enum logic {
    STOP = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [1:0] SEL_GREEN = 2'b01;
  localparam logic [1:0] SEL_RED   = 2'b10;
  localparam logic [1:0] SEL_BOTH  = 2'b11;

  localparam int ROWS_PER_CHAR = 8;

  function automatic logic [1:0] next_sel(input logic [1:0] s);
    logic [1:0] n;
    case (s)
      SEL_GREEN: n = SEL_RED;
      SEL_RED:   n = SEL_BOTH;
      default:   n = SEL_GREEN;
    endcase
    return n;
  endfunction

  function automatic logic [6:0] char_base(input logic [3:0] d);
    logic [6:0] w;
    w = {3'b000, d};
    return w * 7'(ROWS_PER_CHAR);
  endfunction

endpackage

// File: rtl/matrix_digit_ctrl_btn_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, stable-level debouncer, press pulse.
// After reset the button must read low for DEB_CYCLES samples before presses count.
module btn_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic press_o
);

  localparam logic [7:0] CNT_LAST = 8'(DEB_CYCLES - 1);

  logic [1:0] sync_q;
  logic [7:0] cnt_q, cnt_d;
  logic       level_q, level_d;
  logic       armed_q, armed_d;
  logic       press_q, press_d;
  logic       smp;

  assign smp = sync_q[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= 2'b00;
      cnt_q   <= 8'd0;
      level_q <= 1'b0;
      armed_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      armed_q <= armed_d;
      press_q <= press_d;
    end
  end

  always_comb begin
    level_d = level_q;
    armed_d = armed_q;
    press_d = 1'b0;
    cnt_d   = 8'd0;
    if (!armed_q) begin
      // Stay disarmed until a debounced release, so a button held through reset is ignored
      if (!smp) begin
        if (cnt_q == CNT_LAST) armed_d = 1'b1;
        else                   cnt_d   = cnt_q + 8'd1;
      end
    end else if (smp != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = smp;
        press_d = smp;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/matrix_digit_ctrl.sv
// Digit/colour sequencer for the LED matrix: STOP/RUN FSM driven by debounced buttons and tick.
// Optional macro DOWN_COUNT_EN adds a direction button that toggles up/down counting.
module matrix_digit_ctrl
  import matrix_digit_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter int NUM_DIGITS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       btn_mode,
  input  logic       btn_step,
  input  logic       btn_dir,
  output logic [3:0] digit,
  output logic [6:0] digit_idx,
  output logic [1:0] sel,
  output logic       running
);

  localparam logic [3:0] LAST_DIGIT = 4'(NUM_DIGITS - 1);

  state_e     state_q, state_d;
  logic [3:0] digit_q, digit_d, adv_digit;
  logic [6:0] idx_q, idx_d;
  logic [1:0] sel_q, sel_d;
  logic       down_q;
  logic       mode_press, step_press;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_mode (
    .clk(clk), .reset(reset), .btn_i(btn_mode), .press_o(mode_press)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_step (
    .clk(clk), .reset(reset), .btn_i(btn_step), .press_o(step_press)
  );

`ifdef DOWN_COUNT_EN
  logic dir_press;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_dir (
    .clk(clk), .reset(reset), .btn_i(btn_dir), .press_o(dir_press)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) down_q <= 1'b0;
    else       down_q <= down_q ^ dir_press;
  end
`else
  logic unused_btn_dir;
  assign unused_btn_dir = btn_dir;
  assign down_q         = 1'b0;
`endif

  always_comb begin
    if (down_q) adv_digit = (digit_q == 4'd0) ? LAST_DIGIT : digit_q - 4'd1;
    else        adv_digit = (digit_q == LAST_DIGIT) ? 4'd0 : digit_q + 4'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= STOP;
      digit_q <= 4'd0;
      idx_q   <= 7'd0;
      sel_q   <= SEL_GREEN;
    end else begin
      state_q <= state_d;
      digit_q <= digit_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
    end
  end

  // Mode wins over step; in RUN a tick still advances when mode leaves RUN
  always_comb begin
    state_d = state_q;
    digit_d = digit_q;
    sel_d   = sel_q;
    if (state_q == STOP) begin
      if (mode_press)      state_d = RUN;
      else if (step_press) digit_d = adv_digit;
    end else begin
      if (tick)            digit_d = adv_digit;
      if (mode_press)      state_d = STOP;
      else if (step_press) sel_d   = next_sel(sel_q);
    end
    idx_d = char_base(digit_d);
  end

  assign digit     = digit_q;
  assign digit_idx = idx_q;
  assign sel       = sel_q;
  assign running   = (state_q == RUN);

endmodule

// File: tb/tb_matrix_digit_ctrl.sv
// Self-checking bench for matrix_digit_ctrl against a press/tick-level reference model.
module tb_matrix_digit_ctrl;

  localparam int DEB = 4;
  localparam int ND  = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_step = 1'b0;
  logic       btn_dir = 1'b0;
  logic [3:0] digit;
  logic [6:0] digit_idx;
  logic [1:0] sel;
  logic       running;

  int vectors = 0;
  int errors  = 0;

  int m_digit = 0;
  bit m_run   = 0;
  int m_sel_i = 0;
  bit m_down  = 0;

  matrix_digit_ctrl #(.DEB_CYCLES(DEB), .NUM_DIGITS(ND)) dut (
    .clk(clk), .reset(reset), .tick(tick),
    .btn_mode(btn_mode), .btn_step(btn_step), .btn_dir(btn_dir),
    .digit(digit), .digit_idx(digit_idx), .sel(sel), .running(running)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] sel_code(input int i);
    case (i)
      0:       return 2'b01;
      1:       return 2'b10;
      default: return 2'b11;
    endcase
  endfunction

  function automatic logic [13:0] exp_vec();
    return {m_run, sel_code(m_sel_i), 4'(m_digit), 7'(m_digit * 8)};
  endfunction

  function automatic logic [13:0] act_vec();
    return {running, sel, digit, digit_idx};
  endfunction

  function automatic string fmt(input logic [13:0] v);
    return $sformatf("run=%0b sel=%b digit=%0d idx=%0d", v[13], v[12:11], v[10:7], v[6:0]);
  endfunction

  // reference model, one call per accepted event
  task automatic m_reset();
    m_digit = 0; m_run = 0; m_sel_i = 0; m_down = 0;
  endtask

  task automatic m_advance();
    if (m_down) m_digit = (m_digit + ND - 1) % ND;
    else        m_digit = (m_digit + 1) % ND;
  endtask

  task automatic m_mode();
    m_run = !m_run;
  endtask

  task automatic m_step();
    if (!m_run) m_advance();
    else        m_sel_i = (m_sel_i + 1) % 3;
  endtask

  task automatic m_tick();
    if (m_run) m_advance();
  endtask

  task automatic m_dir();
`ifdef DOWN_COUNT_EN
    m_down = !m_down;
`endif
  endtask

  task automatic set_btn(input int which, input logic v);
    case (which)
      0:       btn_mode = v;
      1:       btn_step = v;
      default: btn_dir  = v;
    endcase
  endtask

  task automatic hold_btn(input int which, input int n);
    @(negedge clk);
    set_btn(which, 1'b1);
    repeat (n) @(negedge clk);
    set_btn(which, 1'b0);
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_tick();
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    m_reset();
    settle(2);
    reset = 1'b0;
    settle(12);
  endtask

  task automatic test_reset();
    btn_step = 1'b1;
    settle(2);
    #1;
    vectors++;
    if (act_vec() !== {1'b0, 2'b01, 4'd0, 7'd0}) begin
      errors++;
      $display("FAIL reset_state: got %s want %s", fmt(act_vec()), fmt({1'b0, 2'b01, 4'd0, 7'd0}));
    end
    reset = 1'b0;
    m_reset();
    settle(20);
    btn_step = 1'b0;
    settle(12);
    vectors++;
    if (act_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL held_through_reset: got %s want %s", fmt(act_vec()), fmt(exp_vec()));
    end
  endtask

  task automatic test_glitch();
    hold_btn(1, DEB - 1);
    settle(12);
    vectors++;
    if (act_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL step_glitch: got %s want %s", fmt(act_vec()), fmt(exp_vec()));
    end
  endtask

  task automatic test_run_ticks();
    hold_btn(0, DEB);
    settle(12);
    m_mode();
    vectors++;
    if (act_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL enter_run: got %s want %s", fmt(act_vec()), fmt(exp_vec()));
    end
    for (int i = 1; i <= 10; i++) begin
      pulse_tick();
      settle(2);
      m_tick();
      vectors++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL tick_%0d: got %s want %s", i, fmt(act_vec()), fmt(exp_vec()));
      end
    end
  endtask

  task automatic test_sel_cycle();
    for (int i = 0; i < 3; i++) begin
      hold_btn(1, DEB + 1);
      settle(12);
      m_step();
      vectors++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL sel_rotate_%0d: got %s want %s", i, fmt(act_vec()), fmt(exp_vec()));
      end
    end
    hold_btn(0, DEB);
    settle(12);
    m_mode();
  endtask

  task automatic test_step_stop();
    hold_btn(1, DEB);
    settle(12);
    m_step();
    vectors++;
    if (act_vec() !== exp_vec() || digit !== 4'd1 || digit_idx !== 7'd8) begin
      errors++;
      $display("FAIL stop_step: got %s want %s", fmt(act_vec()), fmt(exp_vec()));
    end
  endtask

  task automatic test_mode_step_same_cycle();
    @(negedge clk);
    btn_mode = 1'b1;
    btn_step = 1'b1;
    settle(DEB);
    btn_mode = 1'b0;
    btn_step = 1'b0;
    settle(12);
    m_mode();
    vectors++;
    if (act_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL mode_step_collide: got %s want %s", fmt(act_vec()), fmt(exp_vec()));
    end
  endtask

  // mode press pulse lands on edge DEB+3 after the button rises; tick is aimed at that edge
  task automatic test_tick_mode_same_cycle();
    @(negedge clk);
    btn_mode = 1'b1;
    for (int k = 1; k <= DEB + 2; k++) begin
      @(negedge clk);
      if (k == DEB)     btn_mode = 1'b0;
      if (k == DEB + 2) tick = 1'b1;
    end
    @(negedge clk);
    tick = 1'b0;
    m_tick();
    m_mode();
    settle(4);
    vectors++;
    if (act_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL tick_mode_collide: got %s want %s", fmt(act_vec()), fmt(exp_vec()));
    end
  endtask

  task automatic test_random();
    int op;
    int n;
    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 4);
      case (op)
        0: begin hold_btn(0, $urandom_range(DEB, DEB + 4)); m_mode(); end
        1: begin hold_btn(1, $urandom_range(DEB, DEB + 4)); m_step(); end
        2: hold_btn($urandom_range(0, 2), $urandom_range(1, DEB - 1));
        3: begin
          n = $urandom_range(1, 3);
          for (int t = 0; t < n; t++) begin
            pulse_tick();
            settle($urandom_range(0, 2));
            m_tick();
          end
        end
        default: begin hold_btn(2, $urandom_range(DEB, DEB + 4)); m_dir(); end
      endcase
      settle(12);
      vectors++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random_op%0d_it%0d: got %s want %s", op, it, fmt(act_vec()), fmt(exp_vec()));
      end
    end
  endtask

`ifdef DOWN_COUNT_EN
  task automatic test_down_count();
    do_reset();
    hold_btn(2, DEB);
    settle(12);
    m_dir();
    hold_btn(1, DEB);
    settle(12);
    m_step();
    vectors++;
    if (act_vec() !== exp_vec() || digit !== 4'd9 || digit_idx !== 7'd72) begin
      errors++;
      $display("FAIL down_wrap: got %s want %s", fmt(act_vec()), fmt(exp_vec()));
    end
  endtask
`endif

  initial begin
    test_reset();
    test_glitch();
    test_run_ticks();
    test_sel_cycle();
    test_step_stop();
    test_mode_step_same_cycle();
    test_tick_mode_same_cycle();
    test_random();
`ifdef DOWN_COUNT_EN
    test_down_count();
`endif
    do_reset();
    vectors++;
    if (act_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL final_reset: got %s want %s", fmt(act_vec()), fmt(exp_vec()));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/matrix_digit_ctrl.md
MATRIX_DIGIT_CTRL -- requirements
Module: matrix_digit_ctrl

Interface
REQ-001 Parameter: DEB_CYCLES, default 4, consecutive stable clocks required to accept a button level (range 2..255).
REQ-002 Parameter: NUM_DIGITS, default 10, digits in the character ROM (range 2..16).
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 tick  input  1  one-cycle auto-advance strobe from the frame-rate divider.
REQ-006 btn_mode  input  1  raw pushbutton, asynchronous, active-high; toggles STOP/RUN.
REQ-007 btn_step  input  1  raw pushbutton, asynchronous, active-high; steps the digit (STOP) or cycles the colour (RUN).
REQ-008 btn_dir  input  1  raw pushbutton, asynchronous, active-high; reverses count direction (used only with DOWN_COUNT_EN).
REQ-009 digit  output  4  current digit, 0..NUM_DIGITS-1.
REQ-010 digit_idx  output  7  ROM base address = digit*8, feeds the row scanner idx input.
REQ-011 sel  output  2  colour select: 01 green, 10 red, 11 both; never 00.
REQ-012 running  output  1  high in RUN state.

Function
REQ-013 Each button SHALL pass a 2-flop synchronizer, then a debouncer that accepts a new level only after DEB_CYCLES consecutive identical synchronized samples.
REQ-014 Each debouncer SHALL emit a one-cycle press pulse on an accepted 0->1 transition; releases and bounces shorter than DEB_CYCLES SHALL produce no pulse.
REQ-015 FSM states: STOP, RUN; a mode press SHALL toggle STOP<->RUN.
REQ-016 In STOP: a step press SHALL advance digit by one; tick SHALL be ignored.
REQ-017 In RUN: tick SHALL advance digit by one; a step press SHALL rotate sel 01->10->11->01.
REQ-018 Advance SHALL wrap NUM_DIGITS-1 -> 0 (up) and 0 -> NUM_DIGITS-1 (down).
REQ-019 Same-cycle mode and step presses: mode SHALL take effect; step SHALL be dropped.
REQ-020 Same-cycle tick and mode press in RUN: digit SHALL advance and state SHALL go to STOP.
REQ-021 All outputs SHALL be registered; a pulse or tick sampled at edge N SHALL be visible on the outputs after edge N+1.
REQ-022 digit_idx SHALL always equal {digit,3'b000} truncated to 7 bits, updated in the same cycle as digit.
REQ-023 running SHALL equal (state==RUN) with no additional latency relative to the state register.

Reset
REQ-024 While reset is high: state=STOP, digit=0, digit_idx=0, sel=01, running=0, direction=up, all synchronizer and debouncer counters/levels cleared to 0.
REQ-025 Reset asserted mid-debounce or mid-count SHALL discard the partial count; a button held through reset release SHALL produce no press until released and re-pressed.

Configuration
REQ-026 Macro DOWN_COUNT_EN defined: btn_dir gets its own synchronizer/debouncer; each press SHALL toggle direction, effective for the next advance.
REQ-027 Macro DOWN_COUNT_EN undefined: btn_dir SHALL be ignored, no logic instantiated for it, direction fixed up.

Structure
REQ-028 Shared package SHALL hold the FSM state encoding (STOP=0, RUN=1), the colour codes SEL_GREEN/SEL_RED/SEL_BOTH and the ROM row count constant ROWS_PER_CHAR=8.
REQ-029 One sub-module, btn_debounce (synchronizer + debouncer + press-pulse), SHALL be instantiated per button.

Verification
REQ-030 Reset, STOP, btn_step held high for 4 clocks then low -> digit 0->1, digit_idx 8, exactly one advance.
REQ-031 btn_step glitch high for 3 clocks (DEB_CYCLES=4) -> no change in digit or sel.
REQ-032 Mode press, then 10 tick pulses from digit 0 -> running=1, digit sequence 1..9,0, digit_idx returns to 0.
REQ-033 In RUN, three step presses -> sel 01->10->11->01, digit unchanged absent ticks.
REQ-034 Mode and step pulses debounced to the same cycle in STOP -> running=1, digit unchanged.
REQ-035 With DOWN_COUNT_EN, dir press then step press at digit 0 in STOP -> digit 9, digit_idx 72.
